uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- 8N1 UART transmitter: 8 data bits, 1 stop bit, no parity, LSB first, line idles high.
- Companion to the existing 8N1 receiver. Pairs with it in loopback and host-link designs.
- Small input FIFO lets the user logic push bytes back-to-back. Frames go out with no idle gap between them.

Parameters:
- CLK_FRE, 50, system clock frequency in MHz.
- UART_RATE, 115200, baud rate in bit/s.
- FIFO_DEPTH, 4, input FIFO depth in bytes. Must be a power of two, 2..16.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- send_en  input  1  write strobe. The byte is accepted on any rising edge where send_en && send_ready.
- send_data  input  8  byte to transmit. Sampled on the accepting edge.
- send_ready  output  1  FIFO not full. Registered.
- tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- tx_pin  output  1  serial output. Registered, no combinational path from inputs.

Behaviour:
- Bit timing
  - BIT_CYC = (CLK_FRE*1000000)/UART_RATE, integer-truncated. Defaults give 434.
  - Every bit (start, data, stop) lasts exactly BIT_CYC clocks.
  - The bit counter is sized to hold BIT_CYC-1 for any legal parameter set. It must not be a fixed 11 bits.
- Reset
  - Asserting rst (synchronous) gives, from the next edge: tx_pin=1, send_ready=1, tx_busy=0.
  - FIFO is emptied, state=IDLE, counters=0.
  - Reset mid-frame aborts the frame. tx_pin goes high on the next edge and queued bytes are discarded.
- FIFO
  - Write pointer, read pointer and count, count range 0..FIFO_DEPTH.
  - send_ready = (count != FIFO_DEPTH).
  - send_en while send_ready=0: the byte is dropped and no state changes.
  - Push and pop on the same edge: count unchanged and both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: tx_pin=1. If count>0, pop the head into the shift register, clear the bit counter, go to START.
  - START: tx_pin=0 for BIT_CYC clocks, then go to DATA with bit index 0.
  - DATA: tx_pin=shift[0] for BIT_CYC clocks, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx_pin=1 for BIT_CYC clocks.
    - On the last STOP clock, if count>0, pop the next byte and go directly to START. This gives back-to-back frames with no extra idle clock.
    - Otherwise go to IDLE.
- Latency and frame length
  - Byte accepted at edge N while IDLE with the FIFO empty: the FIFO shows non-empty after N, IDLE pops at edge N+1, tx_pin goes low from edge N+2.
  - Frame length is exactly 10*BIT_CYC clocks, start-bit falling edge to end of stop bit.
- tx_busy
  - tx_busy = (state != IDLE) || (count != 0). Registered, so it may lag by one clock relative to state.
  - It falls only after the stop bit of the last queued byte completes.
- An input byte is never modified after acceptance. The user may change send_data freely once the accepting edge has passed.

Test Plan:
Bench parameters: CLK_FRE=1, UART_RATE=100000, so BIT_CYC=10; FIFO_DEPTH=4.
- Single byte: reset, then push 0xA5 at edge N.
  - tx_pin low from N+2 for 10 clocks.
  - Then data bits 1,0,1,0,0,1,0,1, each 10 clocks.
  - Then high for 10 clocks. tx_busy falls after the frame. Total frame 100 clocks.
- Back-to-back: push 0x00, 0xFF, 0x55 on consecutive edges.
  - Three frames of 100 clocks each, with no idle clocks between stop and next start.
  - Loopback into the existing receiver returns 0x00, 0xFF, 0x55.
- FIFO full: push 6 bytes 0x01..0x06 on consecutive edges while idle.
  - send_ready goes low once 4 bytes are held (first byte popped to the shifter frees one slot).
  - Strobes issued with send_ready=0 are dropped.
  - Only the accepted bytes are transmitted, in order.
- Simultaneous push/pop: FIFO holds 2 bytes; push a byte on the same edge STOP pops the next.
  - Count stays 2 and the order is preserved.
- Reset mid-frame: assert rst for 1 clock during data bit 3 of 0x3C with 2 more bytes queued.
  - tx_pin=1, send_ready=1, tx_busy=0 on the next edge.
  - No further frames are sent.
- Default parameters (50 MHz, 115200): measure the start-bit width.
  - Exactly 434 clocks. Frame exactly 4340 clocks.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: LSB first, line idles high. A small input FIFO feeds
// the shifter so frames go out back-to-back with no idle gap between them.
module uart_tx #(
  parameter int CLK_FRE    = 50,
  parameter int UART_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_en,
  input  logic [7:0] send_data,
  output logic       send_ready,
  output logic       tx_busy,
  output logic       tx_pin
);

  localparam int BIT_CYC = (CLK_FRE * 1000000) / UART_RATE;
  localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNTF_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNTF_W-1:0] FULL     = CNTF_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [7:0]          mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTF_W-1:0]   count_q, count_d;
  logic                send_ready_q, send_ready_d;
  logic                tx_busy_q, tx_busy_d;
  logic                tx_pin_q, tx_pin_d;

  logic push;
  logic pop;
  logic bit_done;

  always_comb begin
    push      = send_en && send_ready_q;
    pop       = 1'b0;
    bit_done  = (bit_cnt_q == BIT_LAST);
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_pin_d  = 1'b1;

    // tx_pin is derived from the current state, so the line lags the FSM by
    // exactly one clock while every bit keeps its full BIT_CYC width.
    case (state_q)
      IDLE: begin
        tx_pin_d = 1'b1;
        if (count_q != '0) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        tx_pin_d = 1'b0;
        if (bit_done) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        tx_pin_d = shift_q[0];
        if (bit_done) begin
          bit_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        tx_pin_d = 1'b1;
        if (bit_done) begin
          bit_cnt_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = send_data;
    end
    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CNTF_W'(1);
      2'b01:   count_d = count_q - CNTF_W'(1);
      default: count_d = count_q;
    endcase

    send_ready_d = (count_d != FULL);
    tx_busy_d    = (state_q != IDLE) || (count_q != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      send_ready_q <= 1'b1;
      tx_busy_q    <= 1'b0;
      tx_pin_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      send_ready_q <= send_ready_d;
      tx_busy_q    <= tx_busy_d;
      tx_pin_q     <= tx_pin_d;
    end
  end

  assign send_ready = send_ready_q;
  assign tx_busy    = tx_busy_q;
  assign tx_pin     = tx_pin_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: an occupancy/timeline model predicts each frame's
// byte and start cycle; a serial monitor decodes tx_pin and checks against it.
module tb_uart_tx;

  localparam int B     = 10;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * B;

  typedef struct {
    logic [7:0] data;
    int         start_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       send_en;
  logic [7:0] send_data;
  logic       send_ready;
  logic       tx_busy;
  logic       tx_pin;

  logic       rst2 = 1'b1;
  logic       send_en2 = 1'b0;
  logic [7:0] send_data2 = 8'h00;
  logic       send_ready2;
  logic       tx_busy2;
  logic       tx_pin2;

  int         edge_count = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         reset_epoch = 0;
  int         last_pop = -1000000;
  logic [7:0] model_fifo [$];
  exp_t       exp_q [$];

  uart_tx #(.CLK_FRE(1), .UART_RATE(100000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .send_en(send_en), .send_data(send_data),
    .send_ready(send_ready), .tx_busy(tx_busy), .tx_pin(tx_pin)
  );

  uart_tx dut_dflt (
    .clk(clk), .rst(rst2), .send_en(send_en2), .send_data(send_data2),
    .send_ready(send_ready2), .tx_busy(tx_busy2), .tx_pin(tx_pin2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_count <= edge_count + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edge_count);
    end
  endtask

  // Called just after a falling edge; predicts the upcoming rising edge k,
  // then checks the registered flags at the next falling edge.
  task automatic applyStimulus(input bit do_reset, input bit en, input logic [7:0] data);
    int   k;
    int   cnt_before;
    bit   busy_exp;
    exp_t e;
    k          = edge_count + 1;
    cnt_before = model_fifo.size();
    rst        = do_reset;
    send_en    = en;
    send_data  = data;
    if (do_reset) begin
      model_fifo.delete();
      exp_q.delete();
      last_pop = k - FRAME;
      reset_epoch++;
      busy_exp = 1'b0;
    end else begin
      busy_exp = ((k - 1) >= last_pop && (k - 1) < last_pop + FRAME) || (cnt_before != 0);
      if (cnt_before > 0 && k >= last_pop + FRAME) begin
        e.data      = model_fifo.pop_front();
        e.start_cyc = k + 1;
        exp_q.push_back(e);
        last_pop = k;
      end
      if (en && cnt_before != DEPTH) model_fifo.push_back(data);
    end
    @(negedge clk);
    checkOutput("send_ready", 32'(send_ready), 32'(model_fifo.size() != DEPTH));
    checkOutput("tx_busy", 32'(tx_busy), 32'(busy_exp));
    if (do_reset) checkOutput("tx_pin_after_reset", 32'(tx_pin), 32'd1);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'($urandom));
  endtask

  initial begin : monitor
    logic [9:0] bit_val;
    bit         shape_ok;
    int         start_cyc;
    int         epoch;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (tx_pin === 1'b0) begin
        start_cyc = edge_count;
        epoch     = reset_epoch;
        shape_ok  = 1'b1;
        bit_val   = '0;
        for (int i = 0; i < FRAME; i++) begin
          if (i != 0) @(negedge clk);
          if (i % B == 0) bit_val[i / B] = tx_pin;
          else if (tx_pin !== bit_val[i / B]) shape_ok = 1'b0;
        end
        if (epoch == reset_epoch) begin
          checkOutput("frame_shape", 32'(shape_ok && bit_val[0] === 1'b0 && bit_val[9] === 1'b1), 32'd1);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_frame: got frame %0h at edge %0d, expected none", bit_val[8:1], start_cyc);
          end else begin
            e = exp_q.pop_front();
            checkOutput("frame_data", 32'(bit_val[8:1]), 32'(e.data));
            checkOutput("frame_start_cycle", start_cyc, e.start_cyc);
          end
        end
      end
    end
  end

  initial begin : main
    int target;
    int n_edge;
    int fall;
    int low_len;
    int frame_end;

    applyStimulus(1'b1, 1'b0, 8'h00);
    rst2 = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("dflt_ready_after_reset", 32'(send_ready2), 32'd1);
    idleCycles(3);

    // Single byte
    applyStimulus(1'b0, 1'b1, 8'hA5);
    idleCycles(FRAME + 15);

    // Back-to-back frames
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'hFF);
    applyStimulus(1'b0, 1'b1, 8'h55);
    idleCycles(3 * FRAME + 15);

    // Overfill: later strobes are dropped while send_ready is low
    for (int i = 1; i <= 6; i++) applyStimulus(1'b0, 1'b1, 8'(i));
    idleCycles(6 * FRAME);

    // Push on the same edge the STOP state pops the next byte
    applyStimulus(1'b0, 1'b1, 8'h11);
    applyStimulus(1'b0, 1'b1, 8'h22);
    applyStimulus(1'b0, 1'b1, 8'h33);
    target = last_pop + FRAME;
    while (edge_count + 1 < target) applyStimulus(1'b0, 1'b0, 8'($urandom));
    applyStimulus(1'b0, 1'b1, 8'h44);
    idleCycles(4 * FRAME);

    // Random traffic
    for (int i = 0; i < 400; i++) applyStimulus(1'b0, ($urandom_range(0, 3) == 0), 8'($urandom));
    idleCycles(6 * FRAME);

    // Reset in the middle of data bit 3 with more bytes queued
    applyStimulus(1'b0, 1'b1, 8'h3C);
    applyStimulus(1'b0, 1'b1, 8'hC3);
    applyStimulus(1'b0, 1'b1, 8'h99);
    target = last_pop + 4 * B + 6;
    while (edge_count + 1 < target) applyStimulus(1'b0, 1'b0, 8'($urandom));
    applyStimulus(1'b1, 1'b0, 8'h00);
    idleCycles(3 * FRAME);

    // Default parameters: 434-clock bits
    send_en2   = 1'b1;
    send_data2 = 8'hFF;
    @(negedge clk);
    send_en2   = 1'b0;
    send_data2 = 8'h00;
    n_edge     = edge_count;
    fall       = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_pin2 === 1'b0) begin
        fall = edge_count;
        break;
      end
    end
    checkOutput("dflt_start_latency", fall, n_edge + 2);
    low_len = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_pin2 === 1'b0) low_len++;
      else break;
    end
    checkOutput("dflt_start_width", low_len, 434);
    frame_end = -1;
    for (int i = 0; i < 6000; i++) begin
      if (tx_busy2 === 1'b0) begin
        frame_end = edge_count;
        break;
      end
      @(negedge clk);
    end
    checkOutput("dflt_frame_length", frame_end - fall, 4340);

    checkOutput("pending_frames", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
